// File: rtl/load_strobe_gen.sv
// load_strobe_gen
//   Turns a slow or asynchronous trigger into a clean synchronous load-enable
//   pulse for a downstream level-enabled register, and sequences the data word
//   that register captures. d never changes while en is high.
//
//   Parameters
//     WIDTH    width of d / d_load_val
//     PULSE_W  en high time in clk cycles (1..255)
//     HOLDOFF  dead cycles after en falls before the next trigger is accepted (0..255)
//     D_INIT   value of d after reset
//
//   Ports
//     clk         clock, all state changes on the rising edge
//     rst_n       synchronous reset, active-low
//     trig        asynchronous trigger, rising edge requests one pulse
//     d_load      one-cycle request to overwrite d with d_load_val
//     d_load_val  value used by d_load
//     en          registered load-enable, PULSE_W cycles per accepted trigger
//     d           registered data word
//     busy        registered, high while a pulse or holdoff is in progress
//     miss_cnt    triggers dropped while busy, saturating at 255
module load_strobe_gen #(
  parameter int              WIDTH   = 32,
  parameter int              PULSE_W = 1,
  parameter int              HOLDOFF = 4,
  parameter logic [WIDTH-1:0] D_INIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             d_load,
  input  logic [WIDTH-1:0] d_load_val,
  output logic             en,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic [7:0]       miss_cnt
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] HO_LAST = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             en_nx, busy_nx;
  logic [WIDTH-1:0] d_nx;
  logic [7:0]       miss_nx;
  logic             pend, pend_nx;
  logic [WIDTH-1:0] pend_val, pend_val_nx;
  logic             s1, s2, trig_d;
  logic             rise;

  // Synchroniser stage: two flops plus edge-detect delay. Reset to zero so a
  // trigger held high across reset release still produces one rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      s1     <= trig;
      s2     <= s1;
      trig_d <= s2;
    end
  end

  assign rise = s2 & ~trig_d;

  // Control / data register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      en       <= 1'b0;
      busy     <= 1'b0;
      d        <= D_INIT;
      miss_cnt <= 8'd0;
      pend     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      en       <= en_nx;
      busy     <= busy_nx;
      d        <= d_nx;
      miss_cnt <= miss_nx;
      pend     <= pend_nx;
    end
  end

  // Pending value is pure data; its validity is carried by pend.
  always_ff @(posedge clk) begin
    pend_val <= pend_val_nx;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    en_nx       = en;
    busy_nx     = busy;
    d_nx        = d;
    miss_nx     = miss_cnt;
    pend_nx     = pend;
    pend_val_nx = pend_val;

    case (state)
      IDLE: begin
        // A load and a trigger on the same edge both take effect, so the
        // pulse that starts here carries the freshly loaded value.
        if (d_load) d_nx = d_load_val;
        if (rise) begin
          state_nx = PULSE;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = PW_LAST;
        end
      end

      PULSE: begin
        if (rise) miss_nx = sat_inc8(miss_cnt);
        // d must stay stable while en is high; park the request instead.
        if (d_load) begin
          pend_nx     = 1'b1;
          pend_val_nx = d_load_val;
        end
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          en_nx   = 1'b0;
          pend_nx = 1'b0;
          // A request arriving on the exit edge is the latest one and wins.
          if (d_load)    d_nx = d_load_val;
          else if (pend) d_nx = pend_val;
          else           d_nx = wrap_inc(d);
          if (HOLDOFF > 0) begin
            state_nx = HOLD;
            cnt_nx   = HO_LAST;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end
      end

      HOLD: begin
        if (rise)   miss_nx = sat_inc8(miss_cnt);
        if (d_load) d_nx    = d_load_val;
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule
